uart_boot_loader: RTL and testbench

Byte-stream boot protocol decoder that takes bytes from the on-chip UART receiver and turns them into 68k-style RAM write cycles while the CPU is held in boot mode. Sits between the UART (rx_data/rx_avail/rx_avail_clear) and the memory arbiter's boot write port. On the END command it releases boot mode so the CPU can start from the loaded image.

---
 rtl/boot_pkg.sv | 18 +
 rtl/uart_boot_loader.sv | 178 +++++++++++++++++
 tb/tb_uart_boot_loader.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_pkg.sv
// Shared command codes and FSM state encoding for the UART boot loader.
package boot_pkg;

    localparam logic [7:0] BOOT_CMD_SETADDR = 8'h01;
    localparam logic [7:0] BOOT_CMD_DATA    = 8'h02;
    localparam logic [7:0] BOOT_CMD_END     = 8'h03;

    typedef enum logic [2:0] {
        ST_CMD,
        ST_ADDR,
        ST_LEN,
        ST_DATA,
        ST_WRITE,
        ST_CSUM,
        ST_DONE
    } boot_state_e;

endpackage

// File: rtl/uart_boot_loader.sv
// UART byte-stream boot loader: decodes SETADDR/DATA/END frames into RAM byte writes.
// Optional BOOT_CHECKSUM_EN adds a modulo-256 checksum byte after every DATA payload.
module uart_boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_avail,
    output logic              rx_avail_clear,
    output logic              wr_req,
    input  logic              wr_ack,
    output logic [ADDR_W-1:0] addr,
    output logic [15:0]       data_write,
    output logic              uds,
    output logic              lds,
    output logic              rw,
    output logic              bootmode,
    output logic              boot_end,
    output logic              err
);

`ifdef BOOT_CHECKSUM_EN
    localparam boot_state_e ST_AFTER_PAYLOAD = ST_CSUM;
`else
    localparam boot_state_e ST_AFTER_PAYLOAD = ST_CMD;
`endif

    boot_state_e       state_q, state_d;
    logic              consume;
    logic              ack_fire;
    logic [1:0]        idx_q;
    logic [15:0]       remain_q;
    logic [ADDR_W:0]   byte_addr_q;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]        csum_q;
`endif

    assign rw = ~wr_req;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_CMD;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal written here gets a default first, otherwise a missed
    // branch would infer a latch.
    always_comb begin
        state_d  = state_q;
        ack_fire = 1'b0;
        // The cycle right after a clear still sees the old rx_avail, so skip it.
        consume  = rx_avail && !rx_avail_clear &&
                   (state_q inside {ST_CMD, ST_ADDR, ST_LEN, ST_DATA, ST_CSUM});

        case (state_q)
            ST_CMD: begin
                if (consume) begin
                    case (rx_data)
                        BOOT_CMD_SETADDR: state_d = ST_ADDR;
                        BOOT_CMD_DATA:    state_d = ST_LEN;
                        BOOT_CMD_END:     state_d = ST_DONE;
                        default:          state_d = ST_CMD;
                    endcase
                end
            end
            ST_ADDR: begin
                if (consume && idx_q == 2'd2) state_d = ST_CMD;
            end
            ST_LEN: begin
                if (consume && idx_q == 2'd1) begin
                    state_d = ({remain_q[7:0], rx_data} == 16'd0) ? ST_AFTER_PAYLOAD : ST_DATA;
                end
            end
            ST_DATA: begin
                if (consume) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                ack_fire = wr_ack && wr_req;
                if (ack_fire) state_d = (remain_q == 16'd1) ? ST_AFTER_PAYLOAD : ST_DATA;
            end
            ST_CSUM: begin
                if (consume) state_d = ST_CMD;
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_CMD;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_avail_clear <= 1'b0;
            wr_req         <= 1'b0;
            addr           <= '0;
            data_write     <= '0;
            uds            <= 1'b0;
            lds            <= 1'b0;
            bootmode       <= 1'b1;
            boot_end       <= 1'b0;
            err            <= 1'b0;
            idx_q          <= '0;
            remain_q       <= '0;
            byte_addr_q    <= '0;
`ifdef BOOT_CHECKSUM_EN
            csum_q         <= '0;
`endif
        end else begin
            rx_avail_clear <= consume;
            boot_end       <= 1'b0;

            case (state_q)
                ST_CMD: begin
                    if (consume) begin
                        idx_q <= '0;
                        case (rx_data)
                            BOOT_CMD_SETADDR, BOOT_CMD_DATA: ;
                            BOOT_CMD_END: begin
                                bootmode <= 1'b0;
                                boot_end <= 1'b1;
                            end
                            default: err <= 1'b1;
                        endcase
                    end
                end
                ST_ADDR: begin
                    // Shift bytes straight in; the top bits of the 24-bit value fall off.
                    if (consume) begin
                        byte_addr_q <= {byte_addr_q[ADDR_W-8:0], rx_data};
                        idx_q       <= idx_q + 2'd1;
                    end
                end
                ST_LEN: begin
                    if (consume) begin
                        remain_q <= {remain_q[7:0], rx_data};
                        idx_q    <= idx_q + 2'd1;
`ifdef BOOT_CHECKSUM_EN
                        csum_q   <= '0;
`endif
                    end
                end
                ST_DATA: begin
                    if (consume) begin
                        data_write <= {rx_data, rx_data};
                        addr       <= byte_addr_q[ADDR_W:1];
                        uds        <= ~byte_addr_q[0];
                        lds        <= byte_addr_q[0];
                        wr_req     <= 1'b1;
`ifdef BOOT_CHECKSUM_EN
                        csum_q     <= csum_q + rx_data;
`endif
                    end
                end
                ST_WRITE: begin
                    if (ack_fire) begin
                        wr_req      <= 1'b0;
                        uds         <= 1'b0;
                        lds         <= 1'b0;
                        byte_addr_q <= byte_addr_q + (ADDR_W+1)'(1);
                        remain_q    <= remain_q - 16'd1;
                    end
                end
                ST_CSUM: begin
`ifdef BOOT_CHECKSUM_EN
                    if (consume && rx_data != csum_q) err <= 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed self-checking bench for uart_boot_loader; follows BOOT_CHECKSUM_EN if defined.
module tb_uart_boot_loader;

    localparam int ADDR_W = 18;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [7:0]        rx_data;
    logic              rx_avail;
    logic              rx_avail_clear;
    logic              wr_req;
    logic              wr_ack;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data_write;
    logic              uds;
    logic              lds;
    logic              rw;
    logic              bootmode;
    logic              boot_end;
    logic              err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_boot_loader #(.ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .rx_data        (rx_data),
        .rx_avail       (rx_avail),
        .rx_avail_clear (rx_avail_clear),
        .wr_req         (wr_req),
        .wr_ack         (wr_ack),
        .addr           (addr),
        .data_write     (data_write),
        .uds            (uds),
        .lds            (lds),
        .rw             (rw),
        .bootmode       (bootmode),
        .boot_end       (boot_end),
        .err            (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        rx_data  = b;
        rx_avail = 1'b1;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!rx_avail_clear && n < 20);
        rx_avail = 1'b0;
        if (!rx_avail_clear) check("consume_timeout", 32'(rx_avail_clear), 32'd1);
    endtask

    task automatic expect_write(input string tag, input logic [ADDR_W-1:0] a,
                                input logic [15:0] d, input logic u, input logic l);
        int n = 0;
        while (!wr_req && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_req"},  32'(wr_req), 32'd1);
        check({tag, "_lat"},  32'(n), 32'd0);
        check({tag, "_addr"}, 32'(addr), 32'(a));
        check({tag, "_data"}, 32'(data_write), 32'(d));
        check({tag, "_uds"},  32'(uds), 32'(u));
        check({tag, "_lds"},  32'(lds), 32'(l));
        check({tag, "_rw"},   32'(rw), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_hold"}, 32'({wr_req, addr, data_write}), 32'({1'b1, a, d}));
        @(negedge clk);
        wr_ack = 1'b1;
        @(posedge clk);
        #1;
        wr_ack = 1'b0;
        check({tag, "_drop"}, 32'(wr_req), 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        int n;
        reset_n  = 1'b0;
        rx_avail = 1'b0;
        rx_data  = 8'h00;
        wr_ack   = 1'b0;
        #23;
        check("rst_clear",    32'(rx_avail_clear), 32'd0);
        check("rst_wr_req",   32'(wr_req), 32'd0);
        check("rst_addr",     32'(addr), 32'd0);
        check("rst_data",     32'(data_write), 32'd0);
        check("rst_strobes",  32'({uds, lds}), 32'd0);
        check("rst_rw",       32'(rw), 32'd1);
        check("rst_bootmode", 32'(bootmode), 32'd1);
        check("rst_boot_end", 32'(boot_end), 32'd0);
        check("rst_err",      32'(err), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Consume latency: sampled at one edge, clear visible right after it, for one cycle.
        @(negedge clk);
        rx_data  = 8'h01;
        rx_avail = 1'b1;
        @(posedge clk);
        #1;
        check("consume_lat", 32'(rx_avail_clear), 32'd1);
        rx_avail = 1'b0;
        @(posedge clk);
        #1;
        check("consume_pulse", 32'(rx_avail_clear), 32'd0);

        // Frame 1: SETADDR 000010, DATA 2 bytes AA BB.
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'hAA);
        expect_write("f1w0", 18'h00008, 16'hAAAA, 1'b1, 1'b0);
        send_byte(8'hBB);
        expect_write("f1w1", 18'h00008, 16'hBBBB, 1'b0, 1'b1);
`ifdef BOOT_CHECKSUM_EN
        send_byte(8'h65);
`endif
        check("f1_err", 32'(err), 32'd0);

        // Frame 2: odd byte address 3.
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h03);
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h5A);
        expect_write("f2w0", 18'h00001, 16'h5A5A, 1'b0, 1'b1);
`ifdef BOOT_CHECKSUM_EN
        send_byte(8'h5A);
`endif

        // Zero-length payload issues no bus cycle; stray wr_ack is ignored.
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
`ifdef BOOT_CHECKSUM_EN
        send_byte(8'h00);
`endif
        @(negedge clk);
        wr_ack = 1'b1;
        @(negedge clk);
        wr_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("n0_no_req", 32'(wr_req), 32'd0);
        check("n0_err", 32'(err), 32'd0);

`ifdef BOOT_CHECKSUM_EN
        // Bad checksum: write still happens, err sets, next frame decodes normally.
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h44);
        expect_write("cs_w0", 18'h00010, 16'h4444, 1'b1, 1'b0);
        send_byte(8'h00);
        @(posedge clk);
        #1;
        check("cs_err", 32'(err), 32'd1);
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h40);
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h66);
        expect_write("cs_w1", 18'h00020, 16'h6666, 1'b1, 1'b0);
        send_byte(8'h66);
        pulse_reset();
        #1;
        check("cs_err_cleared", 32'(err), 32'd0);
`endif

        // Illegal command sets err, no write; the following frame still runs.
        send_byte(8'h7F);
        @(posedge clk);
        #1;
        check("bad_cmd_err", 32'(err), 32'd1);
        check("bad_cmd_no_req", 32'(wr_req), 32'd0);
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h77);
        expect_write("after_bad", 18'h00002, 16'h7777, 1'b0, 1'b1);
`ifdef BOOT_CHECKSUM_EN
        send_byte(8'h77);
`endif

        // Address wrap: byte address 7FFFF then 00000.
        send_byte(8'h01); send_byte(8'h07); send_byte(8'hFF); send_byte(8'hFF);
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h11);
        expect_write("wrap_w0", 18'h3FFFF, 16'h1111, 1'b0, 1'b1);
        send_byte(8'h22);
        expect_write("wrap_w1", 18'h00000, 16'h2222, 1'b1, 1'b0);
`ifdef BOOT_CHECKSUM_EN
        send_byte(8'h33);
`endif

        // END: boot_end for exactly one cycle, bootmode falls with it.
        send_byte(8'h03);
        check("end_pulse", 32'(boot_end), 32'd1);
        check("end_bootmode", 32'(bootmode), 32'd0);
        @(posedge clk);
        #1;
        check("end_pulse_off", 32'(boot_end), 32'd0);
        check("end_bootmode_hold", 32'(bootmode), 32'd0);
        @(negedge clk);
        rx_data  = 8'h01;
        rx_avail = 1'b1;
        n = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (rx_avail_clear) n++;
        end
        rx_avail = 1'b0;
        check("done_no_consume", 32'(n), 32'd0);

        // Reset during WRITE abandons the write immediately.
        pulse_reset();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h33);
        check("rw_pending", 32'(wr_req), 32'd1);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("rw_req", 32'(wr_req), 32'd0);
        check("rw_bootmode", 32'(bootmode), 32'd1);
        check("rw_outs", 32'({rw, uds, lds, addr}), 32'({1'b1, 1'b0, 1'b0, 18'h0}));
        @(negedge clk);
        reset_n = 1'b1;
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h9C);
        expect_write("post_rst", 18'h00001, 16'h9C9C, 1'b1, 1'b0);
        check("post_rst_err", 32'(err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
